// File: rtl/regfile_wb_arb_if.sv
// Writeback requester bus: per-requester valid/rd/data flattened into vectors
// (slice i belongs to requester i) plus the one-hot ready returned by the arbiter.
//   master : requester side (drives valid/rd/data, samples ready)
//   slave  : arbiter side   (samples valid/rd/data, drives ready)
interface regfile_wb_arb_if #(
  parameter int XLEN = 64,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_rd;
  logic [XLEN*NREQ-1:0] req_data;
  logic [NREQ-1:0]      req_ready;

  modport master (output req_valid, req_rd, req_data, input req_ready);
  modport slave  (input req_valid, req_rd, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter. NREQ requesters (2..4) compete for a single
// register-file write port; round-robin grant, combinational one-hot ready,
// registered write port with fixed 1-cycle latency.
// Optional pending-writeback scoreboard, compiled in with WB_ARB_SCOREBOARD_EN;
// without it pend_mask is tied to 0 and issue_* are ignored.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   bus (slave)         req_valid/req_rd/req_data in, req_ready out
//   wb_stall            blocks all grants while high
//   rf_regWrite/rf_wReg/rf_wData  register-file write port (registered)
//   issue_valid/issue_rd          marks a destination register in flight
//   pend_mask           registers with an outstanding writeback (bit 0 always 0)
module regfile_wb_arb #(
  parameter int XLEN = 64,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              reset,
  regfile_wb_arb_if.slave   bus,
  input  logic              wb_stall,
  output logic              rf_regWrite,
  output logic [4:0]        rf_wReg,
  output logic [XLEN-1:0]   rf_wData,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  output logic [31:0]       pend_mask
);

  logic [1:0]      last_grant;
  logic [1:0]      sel;
  logic            found;
  logic [NREQ-1:0] vld;
  logic [NREQ-1:0] ready;
  logic            xfer;
  logic [4:0]      g_rd;
  logic [XLEN-1:0] g_data;

  assign vld = bus.req_valid;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    sel   = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && vld[(int'(last_grant) + k) % NREQ]) begin
        found = 1'b1;
        sel   = 2'((int'(last_grant) + k) % NREQ);
      end
    end
  end

  // Ready is gated by reset so nothing can be granted while in reset.
  always_comb begin
    ready  = '0;
    g_rd   = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      ready[i] = found && !wb_stall && !reset && (sel == 2'(i));
      if (sel == 2'(i)) begin
        g_rd   = bus.req_rd[i*5 +: 5];
        g_data = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign bus.req_ready = ready;
  assign xfer          = |(vld & ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= 2'(NREQ - 1);
      rf_regWrite <= 1'b0;
      rf_wReg     <= '0;
      rf_wData    <= '0;
    end else begin
      rf_regWrite <= 1'b0;
      if (xfer) begin
        last_grant  <= sel;
        rf_wReg     <= g_rd;
        rf_wData    <= g_data;
        // rd=0 still consumes the grant but must not write x0.
        rf_regWrite <= (g_rd != 5'd0);
      end
    end
  end

`ifdef WB_ARB_SCOREBOARD_EN
  logic [31:1] pend;

  // Set wins over clear on the same register; x0 is never tracked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue_valid && issue_rd == 5'(r))
          pend[r] <= 1'b1;
        else if (xfer && g_rd == 5'(r))
          pend[r] <= 1'b0;
      end
    end
  end

  assign pend_mask = {pend, 1'b0};
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd};
  assign pend_mask    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
module tb_regfile_wb_arb;
  localparam int XLEN = 64;
  localparam int NREQ = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_stall;
  logic            rf_regWrite;
  logic [4:0]      rf_wReg;
  logic [XLEN-1:0] rf_wData;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [31:0]     pend_mask;

  regfile_wb_arb_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  regfile_wb_arb #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .wb_stall    (wb_stall),
    .rf_regWrite (rf_regWrite),
    .rf_wReg     (rf_wReg),
    .rf_wData    (rf_wData),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .pend_mask   (pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic        stall;
    logic [14:0] rd;     // {rd2, rd1, rd0}
    logic [63:0] wd;     // requester i drives wd ^ (i << 32)
    logic [2:0]  ready;  // expected one-hot grant
    logic        we;     // expected rf_regWrite next cycle
    logic [4:0]  wreg;   // expected rf_wReg next cycle
  } vec_t;

  int ncmp = 0;
  int nerr = 0;
  logic [63:0] exp_wdata;
  logic [31:0] exp_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] rds(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    return {a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic [2:0] v, input logic s, input logic [14:0] r, input logic [63:0] w,
                              input logic [2:0] rdy, input logic we, input logic [4:0] wr);
    vec_t t;
    t.valid = v; t.stall = s; t.rd = r; t.wd = w; t.ready = rdy; t.we = we; t.wreg = wr;
    return t;
  endfunction

  task automatic drive(input logic [2:0] v, input logic [14:0] r, input logic [63:0] w);
    bus.req_valid = v;
    bus.req_rd    = r;
    bus.req_data  = {w ^ 64'h2_0000_0000, w ^ 64'h1_0000_0000, w};
  endtask

  vec_t tbl[17];

  initial begin
    logic [14:0] rstd;
    rstd = rds(5'd1, 5'd2, 5'd3);
    tbl[0]  = mk(3'b111, 0, rstd, 64'h100, 3'b001, 1, 5'd1);
    tbl[1]  = mk(3'b111, 0, rstd, 64'h100, 3'b010, 1, 5'd2);
    tbl[2]  = mk(3'b111, 0, rstd, 64'h100, 3'b100, 1, 5'd3);
    tbl[3]  = mk(3'b111, 0, rstd, 64'h100, 3'b001, 1, 5'd1);
    tbl[4]  = mk(3'b111, 0, rstd, 64'h100, 3'b010, 1, 5'd2);
    tbl[5]  = mk(3'b111, 0, rstd, 64'h100, 3'b100, 1, 5'd3);
    tbl[6]  = mk(3'b010, 0, rds(5'd0, 5'd5, 5'd0), 64'h1_DEAD_BEEF, 3'b010, 1, 5'd5);
    tbl[7]  = mk(3'b000, 0, rstd, 64'h777, 3'b000, 0, 5'd5);
    tbl[8]  = mk(3'b001, 0, rds(5'd0, 5'd0, 5'd0), 64'h1, 3'b001, 0, 5'd0);
    tbl[9]  = mk(3'b111, 1, rstd, 64'h200, 3'b000, 0, 5'd0);
    tbl[10] = mk(3'b111, 1, rstd, 64'h200, 3'b000, 0, 5'd0);
    tbl[11] = mk(3'b111, 1, rstd, 64'h200, 3'b000, 0, 5'd0);
    tbl[12] = mk(3'b111, 0, rstd, 64'h300, 3'b010, 1, 5'd2);
    tbl[13] = mk(3'b101, 0, rstd, 64'h300, 3'b100, 1, 5'd3);
    tbl[14] = mk(3'b011, 0, rstd, 64'h300, 3'b001, 1, 5'd1);
    tbl[15] = mk(3'b110, 0, rstd, 64'h300, 3'b010, 1, 5'd2);
    tbl[16] = mk(3'b100, 0, rstd, 64'h300, 3'b100, 1, 5'd3);

    // Reset state, with every requester asking: no grant may appear.
    reset = 1'b1; wb_stall = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;
    drive(3'b111, rstd, 64'h100);
    exp_wdata = '0;
    #1;
    chk("reset_ready", bus.req_ready, 3'b000);
    chk("reset_we",    rf_regWrite, 1'b0);
    chk("reset_wreg",  rf_wReg, 5'd0);
    chk("reset_wdata", rf_wData, 64'h0);
    chk("reset_pend",  pend_mask, 32'h0);
    @(negedge clk);
    drive(3'b000, rstd, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i].valid, tbl[i].rd, tbl[i].wd);
      wb_stall = tbl[i].stall;
      #1;
      chk($sformatf("v%0d_ready", i), bus.req_ready, tbl[i].ready);
      case (tbl[i].ready)
        3'b001: exp_wdata = tbl[i].wd;
        3'b010: exp_wdata = tbl[i].wd ^ 64'h1_0000_0000;
        3'b100: exp_wdata = tbl[i].wd ^ 64'h2_0000_0000;
        default: ;
      endcase
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i),    rf_regWrite, tbl[i].we);
      chk($sformatf("v%0d_wreg", i),  rf_wReg, tbl[i].wreg);
      chk($sformatf("v%0d_wdata", i), rf_wData, exp_wdata);
    end
    chk("last_wdata", rf_wData, 64'h2_0000_0300);

`ifdef WB_ARB_SCOREBOARD_EN
    exp_pend = 32'h0000_0080;
`else
    exp_pend = 32'h0;
`endif
    // Issue rd=7, then transfer rd=7 alongside a fresh issue of rd=7 (set wins).
    @(negedge clk);
    drive(3'b000, rstd, 64'h0); wb_stall = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(posedge clk); #1;
    chk("pend_set7", pend_mask, exp_pend);
    @(negedge clk);
    drive(3'b001, rds(5'd7, 5'd0, 5'd0), 64'h55);
    #1;
    chk("sw_ready", bus.req_ready, 3'b001);
    @(posedge clk); #1;
    chk("sw_we",   rf_regWrite, 1'b1);
    chk("sw_wreg", rf_wReg, 5'd7);
    chk("sw_pend", pend_mask, exp_pend);
    @(negedge clk);
    issue_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr_pend", pend_mask, 32'h0);
    chk("clr_we",   rf_regWrite, 1'b1);
    @(negedge clk);
    drive(3'b000, rstd, 64'h0);
    issue_valid = 1'b1; issue_rd = 5'd0;
    @(posedge clk); #1;
    chk("x0_pend", pend_mask, 32'h0);
    chk("idle_we", rf_regWrite, 1'b0);

    // Grant rd=9 while rd=12 is issued, then reset in the following cycle.
    @(negedge clk);
    drive(3'b001, rds(5'd9, 5'd0, 5'd0), 64'h99);
    issue_valid = 1'b1; issue_rd = 5'd12;
    #1;
    chk("r9_ready", bus.req_ready, 3'b001);
    @(posedge clk); #1;
    chk("r9_we", rf_regWrite, 1'b1);
`ifdef WB_ARB_SCOREBOARD_EN
    chk("r9_pend", pend_mask, 32'h0000_1000);
`else
    chk("r9_pend", pend_mask, 32'h0);
`endif
    #1;
    reset = 1'b1;
    #1;
    chk("rst_ready", bus.req_ready, 3'b000);
    chk("rst_we",    rf_regWrite, 1'b0);
    chk("rst_wreg",  rf_wReg, 5'd0);
    chk("rst_wdata", rf_wData, 64'h0);
    chk("rst_pend",  pend_mask, 32'h0);
    @(negedge clk);
    drive(3'b000, rstd, 64'h0);
    issue_valid = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_we%0d", c), rf_regWrite, 1'b0);
      chk($sformatf("post_rst_pend%0d", c), pend_mask, 32'h0);
    end

    // After reset requester 0 has first priority again.
    @(negedge clk);
    drive(3'b111, rstd, 64'h400);
    #1;
    chk("post_rst_prio", bus.req_ready, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
